// File: rtl/shift_unit_seq_pkg.sv
// Shared types for the sequential shift unit: operation modes, FSM state
// encoding and a width helper for the per-step shift amount.
// Optional rotate support is controlled by SHIFT_UNIT_ROTATE_EN.
package shift_pkg;

   typedef enum logic [1:0] {
      SHIFT_SLL = 2'b00,
      SHIFT_SRL = 2'b01,
      SHIFT_SRA = 2'b10,
      SHIFT_ROL = 2'b11
   } shift_mode_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   // Bits needed to carry a per-step amount in the range 0..step.
   function automatic int step_k_w(input int step);
      return (step < 1) ? 1 : $clog2(step + 1);
   endfunction

endpackage

// File: rtl/shift_unit_seq_step.sv
// Combinational single-step shifter: moves acc by k (0..STEP) positions in
// the requested mode and reports the last bit that left the word.
// Rotate hardware only exists when SHIFT_UNIT_ROTATE_EN is defined; otherwise
// the rotate encoding falls through to a logical left shift.
module shift_step
   import shift_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int K_W   = 1
) (
   input  logic [WIDTH-1:0] acc,
   input  logic [K_W-1:0]   k,
   input  shift_mode_t      mode,
   output logic [WIDTH-1:0] acc_next,
   output logic             carry
);

   // One extra bit beside the word catches the bit shifted out.
   logic [WIDTH:0] sll_s;
   logic [WIDTH:0] srl_s;
   logic [WIDTH:0] sra_s;

`ifdef SHIFT_UNIT_ROTATE_EN
   localparam int IDX_W = $clog2(WIDTH);

   logic [WIDTH-1:0] rol_s;
   logic [IDX_W-1:0] k_idx_s;

   // Rotate left: index arithmetic wraps naturally because WIDTH is a power of two.
   always_comb begin
      rol_s   = {WIDTH{1'b0}};
      k_idx_s = IDX_W'(k);
      for (int i = 0; i < WIDTH; i++) begin
         rol_s[i] = acc[IDX_W'(i) - k_idx_s];
      end
   end
`endif

   // Form every candidate shift, then select the one for the active mode.
   always_comb begin
      sll_s = {1'b0, acc} << k;
      srl_s = {acc, 1'b0} >> k;
      sra_s = $signed({acc, 1'b0}) >>> k;
      case (mode)
         SHIFT_SRL: begin
            acc_next = srl_s[WIDTH:1];
            carry    = srl_s[0];
         end
         SHIFT_SRA: begin
            acc_next = sra_s[WIDTH:1];
            carry    = sra_s[0];
         end
`ifdef SHIFT_UNIT_ROTATE_EN
         SHIFT_ROL: begin
            acc_next = rol_s;
            carry    = rol_s[0];
         end
`endif
         default: begin
            acc_next = sll_s[WIDTH-1:0];
            carry    = sll_s[WIDTH];
         end
      endcase
   end

endmodule

// File: rtl/shift_unit_seq.sv
// Multi-cycle shift unit: accepts an operand and amount with start, shifts up
// to STEP positions per clock, then pulses done with result and carry_out.
// Define SHIFT_UNIT_ROTATE_EN to give mode 11 rotate-left behaviour.
module shift_unit_seq
   import shift_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int SHAMT_W = $clog2(WIDTH),
   parameter int STEP    = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [1:0]         mode,
   input  logic [WIDTH-1:0]   operand,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   result,
   output logic               carry_out,
   output logic               zero
);

   localparam int K_W = step_k_w(STEP);

   state_t             state_r;
   state_t             state_next_s;
   logic [WIDTH-1:0]   acc_r;
   logic [SHAMT_W-1:0] rem_r;
   logic [SHAMT_W-1:0] rem_next_s;
   shift_mode_t        mode_r;
   logic [WIDTH-1:0]   result_r;
   logic               carry_r;
   logic               done_r;
   logic               busy_r;
   logic [K_W-1:0]     k_s;
   logic [WIDTH-1:0]   step_acc_s;
   logic               step_carry_s;

   shift_step #(
      .WIDTH (WIDTH),
      .K_W   (K_W)
   ) u_step (
      .acc      (acc_r),
      .k        (k_s),
      .mode     (mode_r),
      .acc_next (step_acc_s),
      .carry    (step_carry_s)
   );

   // Amount applied this clock is the smaller of what remains and STEP.
   always_comb begin
      k_s = {K_W{1'b0}};
      if (int'(rem_r) > STEP) begin
         k_s = K_W'(STEP);
      end else begin
         k_s = K_W'(rem_r);
      end
      rem_next_s = rem_r - SHAMT_W'(k_s);
   end

   // Next-state logic: IDLE -> RUN/DONE on accept, RUN until remaining hits 0.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               if (shamt != {SHAMT_W{1'b0}}) begin
                  state_next_s = ST_RUN;
               end else begin
                  state_next_s = ST_DONE;
               end
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (rem_next_s == {SHAMT_W{1'b0}}) begin
               state_next_s = ST_DONE;
            end else begin
               state_next_s = ST_RUN;
            end
         end
         ST_DONE: state_next_s = ST_IDLE;
         default: state_next_s = ST_IDLE;
      endcase
   end

   // State register; reset abandons any operation in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Datapath and registered outputs; done is a single-cycle pulse after DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_r    <= {WIDTH{1'b0}};
         rem_r    <= {SHAMT_W{1'b0}};
         mode_r   <= SHIFT_SLL;
         result_r <= {WIDTH{1'b0}};
         carry_r  <= 1'b0;
         done_r   <= 1'b0;
         busy_r   <= 1'b0;
      end else begin
         done_r <= 1'b0;
         busy_r <= (state_next_s != ST_IDLE);
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  acc_r   <= operand;
                  rem_r   <= shamt;
                  mode_r  <= shift_mode_t'(mode);
                  carry_r <= 1'b0;
               end
            end
            ST_RUN: begin
               acc_r   <= step_acc_s;
               rem_r   <= rem_next_s;
               carry_r <= step_carry_s;
            end
            ST_DONE: begin
               result_r <= acc_r;
               done_r   <= 1'b1;
            end
            default: begin
               done_r <= 1'b0;
            end
         endcase
      end
   end

   assign busy      = busy_r;
   assign done      = done_r;
   assign result    = result_r;
   assign carry_out = carry_r;
   assign zero      = (result_r == {WIDTH{1'b0}});

endmodule

// File: tb/tb_shift_unit_seq.sv
// Scoreboard bench for shift_unit_seq: one instance with STEP=1 and one with
// STEP=4. Stimulus pushes hand-computed expectations; monitors pop on done.
module tb_shift_unit_seq;

   typedef struct {
      logic [15:0] res;
      logic        c;
      int          lat;
      int          t0;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start1;
   logic        start4;
   logic [1:0]  mode;
   logic [15:0] operand;
   logic [3:0]  shamt;

   logic        busy1, done1, carry1, zero1;
   logic [15:0] result1;
   logic        busy4, done4, carry4, zero4;
   logic [15:0] result4;

   int   cyc    = 0;
   int   n_chk  = 0;
   int   n_bad  = 0;
   exp_t q1[$];
   exp_t q4[$];
   exp_t e1;
   exp_t e4;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   shift_unit_seq #(.WIDTH(16), .STEP(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .mode(mode), .operand(operand),
      .shamt(shamt), .busy(busy1), .done(done1), .result(result1),
      .carry_out(carry1), .zero(zero1)
   );

   shift_unit_seq #(.WIDTH(16), .STEP(4)) u_dut4 (
      .clk(clk), .rst(rst), .start(start4), .mode(mode), .operand(operand),
      .shamt(shamt), .busy(busy4), .done(done4), .result(result4),
      .carry_out(carry4), .zero(zero4)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor for the STEP=1 instance.
   always @(negedge clk) begin
      if (!rst && done1) begin
         if (q1.size() == 0) begin
            n_chk++;
            n_bad++;
            $display("FAIL s1 unexpected done: result 0x%0h, expected no done", result1);
         end else begin
            e1 = q1.pop_front();
            check("s1 result", result1, e1.res);
            check("s1 carry", carry1, e1.c);
            check("s1 zero", zero1, e1.res == 16'h0000);
            check("s1 latency", cyc - e1.t0, e1.lat);
         end
      end
   end

   // Monitor for the STEP=4 instance.
   always @(negedge clk) begin
      if (!rst && done4) begin
         if (q4.size() == 0) begin
            n_chk++;
            n_bad++;
            $display("FAIL s4 unexpected done: result 0x%0h, expected no done", result4);
         end else begin
            e4 = q4.pop_front();
            check("s4 result", result4, e4.res);
            check("s4 carry", carry4, e4.c);
            check("s4 zero", zero4, e4.res == 16'h0000);
            check("s4 latency", cyc - e4.t0, e4.lat);
         end
      end
   end

   task automatic issue(input int which, input logic [1:0] m, input logic [15:0] op,
                        input logic [3:0] sh, input logic [15:0] er, input logic ec,
                        input bit push);
      exp_t e;
      int   step;
      step = (which == 4) ? 4 : 1;
      @(negedge clk);
      mode    = m;
      operand = op;
      shamt   = sh;
      if (which == 4) start4 = 1'b1;
      else            start1 = 1'b1;
      @(posedge clk);
      #1;
      e.res = er;
      e.c   = ec;
      e.t0  = cyc;
      e.lat = 1 + (int'(sh) + step - 1) / step;
      if (push) begin
         if (which == 4) q4.push_back(e);
         else            q1.push_back(e);
      end
      @(negedge clk);
      start1  = 1'b0;
      start4  = 1'b0;
      mode    = ~m;
      operand = ~op;
      shamt   = ~sh;
   endtask

   task automatic drain(input int which);
      int left;
      for (int i = 0; i < 100; i++) begin
         left = (which == 4) ? q4.size() : q1.size();
         if (left == 0) break;
         @(negedge clk);
      end
      left = (which == 4) ? q4.size() : q1.size();
      if (left != 0) begin
         n_chk++;
         n_bad++;
         $display("FAIL drain timeout s%0d: %0d pending, expected 0", which, left);
         if (which == 4) q4.delete();
         else            q1.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      rst     = 1'b1;
      start1  = 1'b0;
      start4  = 1'b0;
      mode    = 2'b00;
      operand = 16'h0000;
      shamt   = 4'h0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset busy", busy1, 1'b0);
      check("reset done", done1, 1'b0);
      check("reset result", result1, 16'h0000);
      check("reset carry", carry1, 1'b0);

      // STEP=1 directed vectors
      issue(1, 2'b00, 16'h0001, 4'd1, 16'h0002, 1'b0, 1'b1); drain(1);
      repeat (3) @(negedge clk);
      check("hold result", result1, 16'h0002);
      check("hold done", done1, 1'b0);
      issue(1, 2'b00, 16'hFFFF, 4'd1,  16'hFFFE, 1'b1, 1'b1); drain(1);
      issue(1, 2'b00, 16'h8000, 4'd1,  16'h0000, 1'b1, 1'b1); drain(1);
      issue(1, 2'b10, 16'h8000, 4'd15, 16'hFFFF, 1'b0, 1'b1); drain(1);
      issue(1, 2'b01, 16'h8000, 4'd15, 16'h0001, 1'b0, 1'b1); drain(1);
      issue(1, 2'b00, 16'h1234, 4'd0,  16'h1234, 1'b0, 1'b1); drain(1);
      issue(1, 2'b01, 16'h0007, 4'd2,  16'h0001, 1'b1, 1'b1); drain(1);
`ifdef SHIFT_UNIT_ROTATE_EN
      issue(1, 2'b11, 16'h8001, 4'd1,  16'h0003, 1'b1, 1'b1); drain(1);
`else
      issue(1, 2'b11, 16'h8001, 4'd1,  16'h0002, 1'b1, 1'b1); drain(1);
`endif

      // STEP=4 directed vectors
      issue(4, 2'b01, 16'h8000, 4'd15, 16'h0001, 1'b0, 1'b1); drain(4);
      issue(4, 2'b10, 16'h8421, 4'd6,  16'hFE10, 1'b1, 1'b1); drain(4);
      issue(4, 2'b00, 16'h000F, 4'd13, 16'hE000, 1'b1, 1'b1); drain(4);

      // Second start mid-RUN must be ignored
      issue(1, 2'b01, 16'h8000, 4'd15, 16'h0001, 1'b0, 1'b1);
      repeat (3) @(negedge clk);
      mode    = 2'b00;
      operand = 16'hFFFF;
      shamt   = 4'd1;
      start1  = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      drain(1);
      repeat (20) @(negedge clk);

      // Reset mid-RUN discards the operation
      issue(1, 2'b10, 16'hFFFF, 4'd15, 16'hFFFF, 1'b1, 1'b0);
      repeat (3) @(negedge clk);
      check("pre-reset busy", busy1, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      check("midrst busy", busy1, 1'b0);
      check("midrst done", done1, 1'b0);
      check("midrst result", result1, 16'h0000);
      check("midrst carry", carry1, 1'b0);
      rst = 1'b0;
      issue(1, 2'b00, 16'h0003, 4'd2, 16'h000C, 1'b0, 1'b1); drain(1);
      repeat (20) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
      $finish;
   end

endmodule
